// File: rtl/night_rider_decoder_if.sv
// LED bus between the night-rider generator (master) and its receive-side
// checker (slave): the sampled LED vector plus the checker's status outputs.
interface night_rider_decoder_if #(
  parameter int N     = 8,
  parameter int CNT_W = 8
);
  logic [N-1:0]         led_in;
  logic                 led_valid;
  logic [$clog2(N)-1:0] pos;
  logic                 dir;
  logic                 locked;
  logic                 step_ok;
  logic                 err;
  logic [CNT_W-1:0]     err_cnt;

  modport master (
    output led_in, led_valid,
    input  pos, dir, locked, step_ok, err, err_cnt
  );

  modport slave (
    input  led_in, led_valid,
    output pos, dir, locked, step_ok, err, err_cnt
  );
endinterface

// File: rtl/night_rider_decoder.sv
// Receive-side checker for the night-rider LED bus. Decodes the lit LED of
// each accepted one-hot sample, tracks the bounce direction, locks after
// LOCK_CNT consecutive correct steps and counts protocol violations.
module night_rider_decoder #(
  parameter int N        = 8,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  night_rider_decoder_if.slave bus
);
  localparam int PW = $clog2(N);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic signed [PW:0] ONE = 1;

  typedef enum logic [1:0] {HUNT, FIRST, TRACK, LOCK} state_t;

  state_t           state_p1;
  logic [PW-1:0]    pos_p1;
  logic             dir_p1;
  logic             locked_p1;
  logic             step_ok_p1;
  logic             err_p1;
  logic [CNT_W-1:0] err_cnt_p1;
  logic [GW-1:0]    good_cnt_p1;

  logic             onehot;
  logic [PW-1:0]    idx;
  logic [PW-1:0]    exp_idx;
  logic             exp_dir;
  logic             tracking;
  logic             good;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic is_adjacent(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic signed [PW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d == ONE) || (d == -ONE);
  endfunction

  // Stage 0: decode the incoming sample and judge it against the tracked position
  always_comb begin
    onehot = (bus.led_in != '0) && ((bus.led_in & (bus.led_in - N'(1))) == '0);
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.led_in[i]) idx = PW'(i);
    end
    if (dir_p1) begin
      if (pos_p1 < PW'(N - 1)) begin
        exp_idx = pos_p1 + PW'(1);
        exp_dir = 1'b1;
      end else begin
        exp_idx = PW'(N - 2);
        exp_dir = 1'b0;
      end
    end else begin
      if (pos_p1 != '0) begin
        exp_idx = pos_p1 - PW'(1);
        exp_dir = 1'b0;
      end else begin
        exp_idx = PW'(1);
        exp_dir = 1'b1;
      end
    end
    tracking = (state_p1 == FIRST) || (state_p1 == TRACK) || (state_p1 == LOCK);
    case (state_p1)
      FIRST:       good = onehot && is_adjacent(idx, pos_p1);
      TRACK, LOCK: good = onehot && (idx == exp_idx);
      default:     good = onehot;
    endcase
  end

  // Stage 1: tracker FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1    <= HUNT;
      pos_p1      <= '0;
      dir_p1      <= 1'b1;
      locked_p1   <= 1'b0;
      step_ok_p1  <= 1'b0;
      err_p1      <= 1'b0;
      err_cnt_p1  <= '0;
      good_cnt_p1 <= '0;
    end else begin
      step_ok_p1 <= 1'b0;
      err_p1     <= 1'b0;
      if (bus.led_valid) begin
        if (!tracking) begin
          locked_p1 <= 1'b0;
          if (onehot) begin
            pos_p1   <= idx;
            state_p1 <= FIRST;
          end else begin
            err_p1     <= 1'b1;
            err_cnt_p1 <= sat_inc(err_cnt_p1);
            state_p1   <= HUNT;
          end
        end else if (!good) begin
          err_p1      <= 1'b1;
          err_cnt_p1  <= sat_inc(err_cnt_p1);
          locked_p1   <= 1'b0;
          good_cnt_p1 <= '0;
          if (onehot) begin
            pos_p1   <= idx;
            state_p1 <= FIRST;
          end else begin
            state_p1 <= HUNT;
          end
        end else begin
          step_ok_p1 <= 1'b1;
          pos_p1     <= idx;
          case (state_p1)
            FIRST: begin
              dir_p1      <= (idx > pos_p1);
              good_cnt_p1 <= GW'(1);
              if (LOCK_CNT == 1) begin
                state_p1  <= LOCK;
                locked_p1 <= 1'b1;
              end else begin
                state_p1  <= TRACK;
              end
            end
            TRACK: begin
              dir_p1      <= exp_dir;
              good_cnt_p1 <= good_cnt_p1 + GW'(1);
              if (good_cnt_p1 + GW'(1) == GW'(LOCK_CNT)) begin
                state_p1  <= LOCK;
                locked_p1 <= 1'b1;
              end
            end
            default: begin
              dir_p1 <= exp_dir;
            end
          endcase
        end
      end
    end
  end

  assign bus.pos     = pos_p1;
  assign bus.dir     = dir_p1;
  assign bus.locked  = locked_p1;
  assign bus.step_ok = step_ok_p1;
  assign bus.err     = err_p1;
  assign bus.err_cnt = err_cnt_p1;
endmodule

// File: tb/tb_night_rider_decoder.sv
// Directed bench for night_rider_decoder: one N=8/CNT_W=8 instance for the
// tracking scenarios and one N=8/CNT_W=2 instance for counter saturation.
module tb_night_rider_decoder;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  night_rider_decoder_if #(.N(8), .CNT_W(8)) bus_a ();
  night_rider_decoder_if #(.N(8), .CNT_W(2)) bus_b ();

  night_rider_decoder #(.N(8), .LOCK_CNT(4), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  night_rider_decoder #(.N(8), .LOCK_CNT(4), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct packed {
    logic [2:0] pos;
    logic       dir;
    logic       locked;
    logic       step_ok;
    logic       err;
    logic [7:0] err_cnt;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic obs_t mk(input int p, input logic d, input logic lk,
                              input logic so, input logic er, input int cnt);
    obs_t o;
    o.pos     = 3'(p);
    o.dir     = d;
    o.locked  = lk;
    o.step_ok = so;
    o.err     = er;
    o.err_cnt = 8'(cnt);
    return o;
  endfunction

  // Drive one cycle on the selected bus, queue its expectation, then compare
  // the registered outputs after the edge.
  task automatic step(input bit sel, input logic r, input logic v,
                      input logic [7:0] led, input obs_t e, input string tag);
    exp_t x;
    obs_t o;
    @(negedge clk);
    rst = r;
    if (sel) begin
      bus_b.led_in    = led;
      bus_b.led_valid = v;
    end else begin
      bus_a.led_in    = led;
      bus_a.led_valid = v;
    end
    x.v   = e;
    x.tag = tag;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    if (sel)
      o = {bus_b.pos, bus_b.dir, bus_b.locked, bus_b.step_ok, bus_b.err, {6'b0, bus_b.err_cnt}};
    else
      o = {bus_a.pos, bus_a.dir, bus_a.locked, bus_a.step_ok, bus_a.err, bus_a.err_cnt};
    x = sbq.pop_front();
    checks++;
    assert (o === x.v)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", x.tag, o, x.v);
    end
  endtask

  // A correct step from prev to p; the expected direction is that of the move.
  task automatic walk(input bit sel, input int p, input int prev, input logic lk,
                      input int cnt, input string tag);
    logic [7:0] led;
    led = 8'(1 << p);
    step(sel, 1'b0, 1'b1, led, mk(p, (p > prev), lk, 1'b1, 1'b0, cnt), tag);
  endtask

  initial begin
    int gp;
    int prev;
    int m;
    logic [7:0] garbage;

    rst             = 1'b1;
    bus_a.led_in    = '0;
    bus_a.led_valid = 1'b0;
    bus_b.led_in    = '0;
    bus_b.led_valid = 1'b0;

    // Reset state, with valid asserted to show reset wins
    step(0, 1'b1, 1'b1, 8'h18, mk(0, 1, 0, 0, 0, 0), "rst_a");
    step(1, 1'b1, 0, 8'hff, mk(0, 1, 0, 0, 0, 0), "rst_b");

    // Generator sweep: 100 samples, both ends, locks after the 5th sample
    prev = 0;
    for (int k = 0; k < 100; k++) begin
      m  = k % 14;
      gp = (m < 8) ? m : 14 - m;
      step(0, 1'b0, 1'b1, 8'(1 << gp),
           mk(gp, (k == 0) ? 1'b1 : (gp > prev), (k >= 4), (k >= 1), 1'b0, 0), "gen_sweep");
      prev = gp;
    end
    // Sweep ends at pos 1 moving up, locked

    // Two LEDs lit while locked -> HUNT; re-acquire 0,1 then relock at 4
    step(0, 1'b0, 1'b1, 8'h18, mk(1, 1, 0, 0, 1, 1), "t2_two_hot");
    step(0, 1'b0, 1'b1, 8'h01, mk(0, 1, 0, 0, 0, 1), "t2_hunt_acq");
    walk(0, 1, 0, 1'b0, 1, "t2_first_step");
    walk(0, 2, 1, 1'b0, 1, "t2_track2");
    walk(0, 3, 2, 1'b0, 1, "t2_track3");
    walk(0, 4, 3, 1'b1, 1, "t2_relock");

    // Bounce round to pos 3 moving up, still locked
    walk(0, 5, 4, 1'b1, 1, "t3_walk");
    walk(0, 6, 5, 1'b1, 1, "t3_walk");
    walk(0, 7, 6, 1'b1, 1, "t3_walk");
    walk(0, 6, 7, 1'b1, 1, "t3_walk");
    walk(0, 5, 6, 1'b1, 1, "t3_walk");
    walk(0, 4, 5, 1'b1, 1, "t3_walk");
    walk(0, 3, 4, 1'b1, 1, "t3_walk");
    walk(0, 2, 3, 1'b1, 1, "t3_walk");
    walk(0, 1, 2, 1'b1, 1, "t3_walk");
    walk(0, 0, 1, 1'b1, 1, "t3_bottom");
    walk(0, 1, 0, 1'b1, 1, "t3_walk");
    walk(0, 2, 1, 1'b1, 1, "t3_walk");
    walk(0, 3, 2, 1'b1, 1, "t3_walk");

    // Skip from 3 to 5 -> violation, re-acquire from 5; then down to 4
    step(0, 1'b0, 1'b1, 8'h20, mk(5, 1, 0, 0, 1, 2), "t3_skip");
    walk(0, 4, 5, 1'b0, 2, "t3_reacq");

    // Relock on the way down, then climb to 6 moving up
    walk(0, 3, 4, 1'b0, 2, "t4_track");
    walk(0, 2, 3, 1'b0, 2, "t4_track");
    walk(0, 1, 2, 1'b1, 2, "t4_lock");
    walk(0, 0, 1, 1'b1, 2, "t4_walk");
    walk(0, 1, 0, 1'b1, 2, "t4_walk");
    walk(0, 2, 1, 1'b1, 2, "t4_walk");
    walk(0, 3, 2, 1'b1, 2, "t4_walk");
    walk(0, 4, 3, 1'b1, 2, "t4_walk");
    walk(0, 5, 4, 1'b1, 2, "t4_walk");
    walk(0, 6, 5, 1'b1, 2, "t4_walk");
    // Top endpoint and turn-around, then a dwell
    walk(0, 7, 6, 1'b1, 2, "t4_top");
    walk(0, 6, 7, 1'b1, 2, "t4_turn");
    step(0, 1'b0, 1'b1, 8'h40, mk(6, 0, 0, 0, 1, 3), "t4_repeat");

    // Relock going down, then 10 idle cycles with garbage on led_in
    walk(0, 5, 6, 1'b0, 3, "t5_track");
    walk(0, 4, 5, 1'b0, 3, "t5_track");
    walk(0, 3, 4, 1'b0, 3, "t5_track");
    walk(0, 2, 3, 1'b1, 3, "t5_lock");
    for (int k = 0; k < 10; k++) begin
      garbage = 8'($urandom);
      step(0, 1'b0, 1'b0, garbage, mk(2, 0, 1, 0, 0, 3), "t5_idle");
    end
    walk(0, 1, 2, 1'b1, 3, "t5_resume");

    // Narrow counter: five violations saturate at 3
    step(1, 1'b0, 1'b1, 8'h00, mk(0, 1, 0, 0, 1, 1), "t6_viol1");
    step(1, 1'b0, 1'b1, 8'h00, mk(0, 1, 0, 0, 1, 2), "t6_viol2");
    step(1, 1'b0, 1'b1, 8'h81, mk(0, 1, 0, 0, 1, 3), "t6_viol3");
    step(1, 1'b0, 1'b1, 8'h00, mk(0, 1, 0, 0, 1, 3), "t6_sat4");
    step(1, 1'b0, 1'b1, 8'hff, mk(0, 1, 0, 0, 1, 3), "t6_sat5");
    // Lock the narrow instance, then reset it while locked
    step(1, 1'b0, 1'b1, 8'h01, mk(0, 1, 0, 0, 0, 3), "t6_acq");
    walk(1, 1, 0, 1'b0, 3, "t6_track");
    walk(1, 2, 1, 1'b0, 3, "t6_track");
    walk(1, 3, 2, 1'b0, 3, "t6_track");
    walk(1, 4, 3, 1'b1, 3, "t6_lock");
    step(1, 1'b1, 1'b1, 8'h20, mk(0, 1, 0, 0, 0, 0), "t6_reset");
    step(1, 1'b0, 1'b0, 8'h20, mk(0, 1, 0, 0, 0, 0), "t6_post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
